// File: rtl/sram_trng_capture_if.sv
// Bus bundle for sram_trng_capture: capture stream, session control, read-back and status.
// ones_count exists only when ONES_CNT_EN is defined.
interface sram_trng_capture_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
);
    logic [DATA_W-1:0] uprocessor_din;
    logic              din_valid;
    logic              start;
    logic              stop;
    logic              clear;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              full;
    logic              done;
    logic              overflow;
`ifdef ONES_CNT_EN
    logic [ADDR_W+$clog2(DATA_W):0] ones_count;
`endif

    modport master (
`ifdef ONES_CNT_EN
        input  ones_count,
`endif
        output uprocessor_din, din_valid, start, stop, clear, rd_addr,
        input  rd_data, wr_addr, count, busy, full, done, overflow
    );

    modport slave (
`ifdef ONES_CNT_EN
        output ones_count,
`endif
        input  uprocessor_din, din_valid, start, stop, clear, rd_addr,
        output rd_data, wr_addr, count, busy, full, done, overflow
    );
endinterface

// File: rtl/sram_trng_capture.sv
// Captures SRAM power-up words into on-chip RAM with skip prefix, full/wrap handling and read-back.
// Optional ONES_CNT_EN adds a popcount accumulator over every stored word (entropy bias monitor).
module sram_trng_capture #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned SKIP_N    = 1,
    parameter int unsigned WRAP_MODE = 0
) (
    input logic                uprocessor_clk,
    input logic                rst,
    sram_trng_capture_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(DEPTH - 1);
    localparam logic [7:0]       SKIP_INIT = 8'(SKIP_N);

    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_CAPTURE, ST_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        skip_q, skip_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              we_c;

    logic [DATA_W-1:0] ram [DEPTH];

    // Session state machine: next-state and flag updates; clear dominates everything.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        count_d    = count_q;
        skip_d     = skip_q;
        full_d     = full_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        we_c       = 1'b0;
        if (bus.clear) begin
            state_d    = ST_IDLE;
            wr_addr_d  = '0;
            count_d    = '0;
            skip_d     = SKIP_INIT;
            full_d     = 1'b0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        wr_addr_d  = '0;
                        count_d    = '0;
                        skip_d     = SKIP_INIT;
                        full_d     = 1'b0;
                        done_d     = 1'b0;
                        overflow_d = 1'b0;
                        state_d    = (SKIP_N > 0) ? ST_SKIP : ST_CAPTURE;
                    end else if (state_q == ST_DONE && bus.din_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                ST_SKIP: begin
                    if (bus.stop) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (bus.din_valid) begin
                        skip_d = skip_q - 8'd1;
                        if (skip_q <= 8'd1) state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.din_valid) begin
                        we_c      = 1'b1;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        count_d   = (count_q == DEPTH_C) ? count_q : count_q + CNT_W'(1);
                        if (count_q == LAST_C) full_d = 1'b1;
                        // Wrap mode: any write once already full overwrites unread data.
                        if (WRAP_MODE != 0 && full_q) overflow_d = 1'b1;
                        if (WRAP_MODE == 0 && count_q == LAST_C) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                    if (bus.stop) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_SKIP) || (state_d == ST_CAPTURE);
    end

`ifdef ONES_CNT_EN
    localparam int unsigned PC_W = $clog2(DATA_W) + 1;
    localparam int unsigned OC_W = ADDR_W + $clog2(DATA_W) + 1;

    logic [OC_W-1:0] ones_q, ones_d;
    logic            session_clr_c;

    function automatic logic [PC_W-1:0] popcnt(input logic [DATA_W-1:0] w);
        logic [PC_W-1:0] s;
        s = '0;
        for (int i = 0; i < DATA_W; i++) s = s + PC_W'(w[i]);
        return s;
    endfunction

    // Accumulator restarts with each accepted start and on clear.
    always_comb begin
        session_clr_c = bus.clear ||
                        (bus.start && (state_q == ST_IDLE || state_q == ST_DONE));
        ones_d = ones_q;
        if (session_clr_c)  ones_d = '0;
        else if (we_c)      ones_d = ones_q + OC_W'(popcnt(bus.uprocessor_din));
    end

    assign bus.ones_count = ones_q;
`endif

    always_ff @(posedge uprocessor_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            count_q    <= '0;
            skip_q     <= SKIP_INIT;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef ONES_CNT_EN
            ones_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            count_q    <= count_d;
            skip_q     <= skip_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            rd_data_q  <= ram[bus.rd_addr];
`ifdef ONES_CNT_EN
            ones_q     <= ones_d;
`endif
        end
    end

    // Storage array: no reset so power-up contents survive for inspection.
    always_ff @(posedge uprocessor_clk) begin
        if (we_c) ram[wr_addr_q] <= bus.uprocessor_din;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.count    = count_q;
    assign bus.busy     = busy_q;
    assign bus.full     = full_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sram_trng_capture.sv
// Directed bench for sram_trng_capture: three configurations side by side with a read-back scoreboard.
// Define ONES_CNT_EN to also exercise the popcount accumulator.
module tb_sram_trng_capture;
    logic uprocessor_clk = 1'b0;
    logic rst = 1'b0;
    always #5 uprocessor_clk = ~uprocessor_clk;

    sram_trng_capture_if #(.DATA_W(8), .ADDR_W(10)) b0 ();
    sram_trng_capture_if #(.DATA_W(8), .ADDR_W(4))  b1 ();
    sram_trng_capture_if #(.DATA_W(8), .ADDR_W(4))  b2 ();

    sram_trng_capture #(.DATA_W(8), .ADDR_W(10), .SKIP_N(1), .WRAP_MODE(0))
        u0 (.uprocessor_clk(uprocessor_clk), .rst(rst), .bus(b0));
    sram_trng_capture #(.DATA_W(8), .ADDR_W(4), .SKIP_N(0), .WRAP_MODE(0))
        u1 (.uprocessor_clk(uprocessor_clk), .rst(rst), .bus(b1));
    sram_trng_capture #(.DATA_W(8), .ADDR_W(4), .SKIP_N(0), .WRAP_MODE(1))
        u2 (.uprocessor_clk(uprocessor_clk), .rst(rst), .bus(b2));

    int tests = 0;
    int fails = 0;
    logic [7:0] m0 [1024];
    logic [7:0] m1 [16];
    logic [7:0] m2 [16];
    logic [7:0] rdq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge uprocessor_clk);
        #1;
    endtask

    // ctl = {start, stop, clear, din_valid}
    task automatic drv(input int d, input bit [3:0] ctl, input logic [7:0] din);
        case (d)
            0: begin b0.start = ctl[3]; b0.stop = ctl[2]; b0.clear = ctl[1]; b0.din_valid = ctl[0]; b0.uprocessor_din = din; end
            1: begin b1.start = ctl[3]; b1.stop = ctl[2]; b1.clear = ctl[1]; b1.din_valid = ctl[0]; b1.uprocessor_din = din; end
            default: begin b2.start = ctl[3]; b2.stop = ctl[2]; b2.clear = ctl[1]; b2.din_valid = ctl[0]; b2.uprocessor_din = din; end
        endcase
    endtask

    task automatic step(input int d, input bit [3:0] ctl, input logic [7:0] din);
        drv(d, ctl, din);
        tick();
        drv(d, 4'b0000, 8'h00);
    endtask

    // Scoreboard read: expectation queued when the address is driven, checked when data returns.
    task automatic rd(input int d, input int a, input string tag);
        logic [7:0] obs;
        case (d)
            0: begin b0.rd_addr = 10'(a); rdq.push_back(m0[10'(a)]); end
            1: begin b1.rd_addr = 4'(a);  rdq.push_back(m1[4'(a)]);  end
            default: begin b2.rd_addr = 4'(a); rdq.push_back(m2[4'(a)]); end
        endcase
        tick();
        case (d)
            0: obs = b0.rd_data;
            1: obs = b1.rd_data;
            default: obs = b2.rd_data;
        endcase
        chk(tag, 64'(obs), 64'(rdq.pop_front()));
    endtask

    logic [7:0] t1 [3];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) drv(d, 4'b0000, 8'h00);
        b0.rd_addr = '0; b1.rd_addr = '0; b2.rd_addr = '0;

        // Reset held with random activity on the inputs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(0, 4'($urandom), 8'($urandom));
            drv(1, 4'($urandom), 8'($urandom));
            b0.rd_addr = 10'($urandom);
            tick();
        end
        chk("rst_busy",     64'(b0.busy),     64'(1'b0));
        chk("rst_full",     64'(b0.full),     64'(1'b0));
        chk("rst_done",     64'(b0.done),     64'(1'b0));
        chk("rst_overflow", 64'(b0.overflow), 64'(1'b0));
        chk("rst_count",    64'(b0.count),    64'(11'd0));
        chk("rst_wr_addr",  64'(b0.wr_addr),  64'(10'd0));
        chk("rst_rd_data",  64'(b0.rd_data),  64'(8'h00));
        chk("rst_busy_u1",  64'(b1.busy),     64'(1'b0));
        drv(0, 4'b0000, 8'h00); drv(1, 4'b0000, 8'h00);
        b0.rd_addr = '0;
        tick();
        rst = 1'b1;
        tick();

        // Skip prefix of one word, then three captured words
        step(0, 4'b1000, 8'h00);
        chk("t1_busy_start", 64'(b0.busy), 64'(1'b1));
        step(0, 4'b0001, 8'h11);
        chk("t1_skip_count", 64'(b0.count), 64'(11'd0));
        t1[0] = 8'hA5; t1[1] = 8'h3C; t1[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0001, t1[i]);
            m0[10'(i)] = t1[i];
        end
        chk("t1_count",   64'(b0.count),   64'(11'd3));
        chk("t1_wr_addr", 64'(b0.wr_addr), 64'(10'd3));
        chk("t1_busy",    64'(b0.busy),    64'(1'b1));
        chk("t1_full",    64'(b0.full),    64'(1'b0));
        b0.rd_addr = 10'd1;
        #1;
        chk("t1_rd_latency_hold", 64'(b0.rd_data), 64'(m0[0]));
        rd(0, 1, "t1_rd1");
        rd(0, 0, "t1_rd0");
        rd(0, 2, "t1_rd2");
        // stop with a same-cycle valid still stores that word
        step(0, 4'b0101, 8'h5A);
        m0[3] = 8'h5A;
        chk("t1_stop_done",  64'(b0.done),    64'(1'b1));
        chk("t1_stop_busy",  64'(b0.busy),    64'(1'b0));
        chk("t1_stop_count", 64'(b0.count),   64'(11'd4));
        chk("t1_stop_ovf",   64'(b0.overflow), 64'(1'b0));
        rd(0, 3, "t1_rd3");
        step(0, 4'b0001, 8'h66);
        chk("t1_done_valid_ovf",   64'(b0.overflow), 64'(1'b1));
        chk("t1_done_valid_count", 64'(b0.count),    64'(11'd4));
        step(0, 4'b0100, 8'h00);
        chk("t1_stop_in_done", 64'(b0.done), 64'(1'b1));

        // Stop-when-full on a 16-word RAM
        step(1, 4'b1000, 8'h00);
        chk("t2_busy_start", 64'(b1.busy), 64'(1'b1));
        for (int i = 0; i < 16; i++) begin
            step(1, 4'b0001, 8'(8'h40 + i));
            m1[4'(i)] = 8'(8'h40 + i);
            if (i == 14) begin
                chk("t2_pre_full",  64'(b1.full),  64'(1'b0));
                chk("t2_pre_busy",  64'(b1.busy),  64'(1'b1));
                chk("t2_pre_count", 64'(b1.count), 64'(5'd15));
            end
        end
        chk("t2_full",    64'(b1.full),     64'(1'b1));
        chk("t2_done",    64'(b1.done),     64'(1'b1));
        chk("t2_busy",    64'(b1.busy),     64'(1'b0));
        chk("t2_count",   64'(b1.count),    64'(5'd16));
        chk("t2_wr_addr", 64'(b1.wr_addr),  64'(4'd0));
        chk("t2_ovf0",    64'(b1.overflow), 64'(1'b0));
        step(1, 4'b0001, 8'hEE);
        chk("t2_ovf1",    64'(b1.overflow), 64'(1'b1));
        chk("t2_count17", 64'(b1.count),    64'(5'd16));
        rd(1, 0, "t2_rd0");
        rd(1, 15, "t2_rd15");

        // Circular overwrite on a 16-word RAM
        step(2, 4'b1000, 8'h00);
        for (int i = 0; i < 18; i++) begin
            if (i == 16) begin
                b2.rd_addr = 4'd0;
                rdq.push_back(m2[0]);
                step(2, 4'b0001, 8'(i));
                chk("t3_rd_during_wr", 64'(b2.rd_data), 64'(rdq.pop_front()));
                chk("t3_ovf_first_overwrite", 64'(b2.overflow), 64'(1'b1));
            end else begin
                step(2, 4'b0001, 8'(i));
            end
            m2[4'(i)] = 8'(i);
            if (i == 15) begin
                chk("t3_full",    64'(b2.full),     64'(1'b1));
                chk("t3_ovf0",    64'(b2.overflow), 64'(1'b0));
                chk("t3_busy",    64'(b2.busy),     64'(1'b1));
                chk("t3_wr_addr_wrap", 64'(b2.wr_addr), 64'(4'd0));
            end
        end
        chk("t3_count",   64'(b2.count),   64'(5'd16));
        chk("t3_wr_addr", 64'(b2.wr_addr), 64'(4'd2));
        rd(2, 0, "t3_rd0");
        rd(2, 1, "t3_rd1");
        rd(2, 2, "t3_rd2");
        step(2, 4'b0100, 8'h00);
        chk("t3_stop_done", 64'(b2.done), 64'(1'b1));
        chk("t3_stop_busy", 64'(b2.busy), 64'(1'b0));
        chk("t3_stop_full", 64'(b2.full), 64'(1'b1));

        // clear beats start and din_valid in the same cycle
        step(1, 4'b1000, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0001, 8'(8'hC0 + i));
            m1[4'(i)] = 8'(8'hC0 + i);
        end
        chk("t4_count5", 64'(b1.count), 64'(5'd5));
        step(1, 4'b1011, 8'h99);
        chk("t4_count",   64'(b1.count),    64'(5'd0));
        chk("t4_wr_addr", 64'(b1.wr_addr),  64'(4'd0));
        chk("t4_busy",    64'(b1.busy),     64'(1'b0));
        chk("t4_done",    64'(b1.done),     64'(1'b0));
        chk("t4_full",    64'(b1.full),     64'(1'b0));
        chk("t4_ovf",     64'(b1.overflow), 64'(1'b0));
        for (int i = 0; i < 6; i++) rd(1, i, $sformatf("t4_rd%0d", i));
        step(1, 4'b0001, 8'h77);
        chk("t4_idle_valid_count", 64'(b1.count), 64'(5'd0));

`ifdef ONES_CNT_EN
        chk("t5_ones_after_clear", 64'(b1.ones_count), 64'(8'd0));
        step(1, 4'b1000, 8'h00);
        step(1, 4'b0001, 8'hFF);
        chk("t5_ones_ff", 64'(b1.ones_count), 64'(8'd8));
        step(1, 4'b0001, 8'h0F);
        step(1, 4'b0001, 8'h00);
        chk("t5_ones_total", 64'(b1.ones_count), 64'(8'd12));
        step(1, 4'b0100, 8'h00);
        step(1, 4'b1000, 8'h00);
        chk("t5_ones_restart", 64'(b1.ones_count), 64'(8'd0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
